// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state and owner encodings for the memory arbiter
package mem_arb_pkg;
   typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, ACK = 2'b10} state_t;
   typedef enum logic {CPU = 1'b0, DBG = 1'b1} owner_t;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter and wait-state sequencer for the shared memory port
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int WAIT_CYC = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   output logic              cpu_stall,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              dbg_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
   state_t            state_q;
   owner_t            owner_q, last_q, gnt_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] rdata_q, wdata_q;
   logic [ADDR_W-1:0] addr_q;
   logic              cpu_ack_q, dbg_ack_q, mem_en_q, mem_we_q;

   // Pick the requester: a lone request wins, a tie goes to the port not served last
   always_comb gnt_d = (cpu_req & dbg_req) ? ((last_q == CPU) ? DBG : CPU) : (dbg_req ? DBG : CPU);

   // Access sequencer: grant in IDLE, hold the port for WAIT_CYC cycles, then pulse the owner's ack
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         owner_q   <= CPU;
         last_q    <= DBG;
         cnt_q     <= '0;
         rdata_q   <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         mem_en_q  <= 1'b0;
         mem_we_q  <= 1'b0;
         cpu_ack_q <= 1'b0;
         dbg_ack_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (cpu_req | dbg_req) begin
               state_q  <= BUSY;
               owner_q  <= gnt_d;
               cnt_q    <= CNT_W'(WAIT_CYC - 1);
               mem_en_q <= 1'b1;
               mem_we_q <= (gnt_d == DBG) ? dbg_we : cpu_we;
               addr_q   <= (gnt_d == DBG) ? dbg_addr : cpu_addr;
               wdata_q  <= (gnt_d == DBG) ? dbg_wdata : cpu_wdata;
            end
            BUSY: if (cnt_q == '0) begin
               if (!mem_we_q) rdata_q <= mem_rdata;
               last_q    <= owner_q;
               mem_en_q  <= 1'b0;
               mem_we_q  <= 1'b0;
               cpu_ack_q <= (owner_q == CPU);
               dbg_ack_q <= (owner_q == DBG);
               state_q   <= ACK;
            end else begin
               cnt_q <= cnt_q - CNT_W'(1);
            end
            ACK: begin
               cpu_ack_q <= 1'b0;
               dbg_ack_q <= 1'b0;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cpu_ack   = cpu_ack_q;
   assign dbg_ack   = dbg_ack_q;
   assign cpu_rdata = rdata_q;
   assign dbg_rdata = rdata_q;
   assign cpu_stall = cpu_req & ~cpu_ack_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a memory model and a WAIT_CYC=1 instance
module tb_mem_arbiter;
   localparam int W = 2;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;

   logic        cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_wdata = '0, dbg_addr = '0, dbg_wdata = '0;
   logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        cpu_ack, dbg_ack, cpu_stall, mem_en, mem_we;

   logic        r1 = 1'b0;
   logic [31:0] a1 = '0, ra1, dra1, ma1, md1, mr1;
   logic        ack1, dack1, st1, en1, we1;

   int n_chk = 0, n_fail = 0;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYC(W)) u_dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYC(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .cpu_req(r1), .cpu_we(1'b0), .cpu_addr(a1), .cpu_wdata(32'h0),
      .cpu_rdata(ra1), .cpu_ack(ack1), .cpu_stall(st1),
      .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(32'h0), .dbg_wdata(32'h0),
      .dbg_rdata(dra1), .dbg_ack(dack1),
      .mem_en(en1), .mem_we(we1), .mem_addr(ma1), .mem_wdata(md1),
      .mem_rdata(mr1)
   );

   function automatic logic [31:0] pat(input int i);
      return (i == 16) ? 32'h8C41_0004 : 32'h1000_0000 + 32'(i) * 7;
   endfunction

   logic [31:0] mem [0:255];
   logic [31:0] shd [0:255];
   assign mem_rdata = mem_en ? mem[mem_addr[9:2]] : 32'h0;
   assign mr1 = en1 ? (ma1 ^ 32'hA5A5_0000) : 32'h0;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = pat(i);
      forever begin
         @(posedge clk);
         if (mem_en && mem_we) mem[mem_addr[9:2]] = mem_wdata;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic        own;
      logic        we;
      logic [31:0] addr;
      logic [31:0] rd;
      int          lat;
   } exp_t;
   exp_t q[$];
   exp_t e;
   logic        lg = 1'b1;
   logic [31:0] last_rd = '0;

   task automatic push(input logic own, input logic we, input logic [31:0] addr, input logic [31:0] wd, input int lat);
      exp_t x;
      if (we) shd[addr[9:2]] = wd;
      else last_rd = shd[addr[9:2]];
      x.own = own; x.we = we; x.addr = addr; x.rd = last_rd; x.lat = lat;
      lg = own;
      q.push_back(x);
   endtask

   int en_cnt = 0, cst = 0, dst = 0;
   always @(negedge clk) begin
      if (rst) begin
         en_cnt = 0; cst = 0; dst = 0;
      end else begin
         if (cpu_stall) cst++;
         if (dbg_req && !dbg_ack) dst++;
         if (mem_en) begin
            en_cnt++;
            if (q.size() == 0) check("unexpected_en", 32'd1, 32'd0);
            else begin
               check("mem_addr", mem_addr, q[0].addr);
               check("mem_we", {31'b0, mem_we}, {31'b0, q[0].we});
            end
         end else check("mem_we_idle", {31'b0, mem_we}, 32'd0);
         if (cpu_ack || dbg_ack) begin
            check("two_acks", {31'b0, cpu_ack & dbg_ack}, 32'd0);
            if (q.size() == 0) check("unexpected_ack", 32'd1, 32'd0);
            else begin
               e = q.pop_front();
               check("owner", {31'b0, dbg_ack}, {31'b0, e.own});
               check("rdata", dbg_ack ? dbg_rdata : cpu_rdata, e.rd);
               check("en_cycles", en_cnt, W);
               check("latency", dbg_ack ? dst : cst, e.lat);
            end
            en_cnt = 0;
            if (cpu_ack) cst = 0;
            if (dbg_ack) dst = 0;
         end
      end
   end

   task automatic wait_done();
      logic ca, da;
      for (int k = 0; k < 40 && (cpu_req || dbg_req); k++) begin
         @(negedge clk);
         ca = cpu_ack; da = dbg_ack;
         @(posedge clk);
         #1;
         if (ca) cpu_req = 1'b0;
         if (da) dbg_req = 1'b0;
      end
      if (cpu_req || dbg_req) begin
         check("timeout", 32'd1, 32'd0);
         cpu_req = 1'b0; dbg_req = 1'b0;
      end
   endtask

   task automatic run(input logic c, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                      input logic d, input logic dw, input logic [31:0] da, input logic [31:0] dd);
      if (c && d) begin
         if (lg) begin push(1'b0, cw, ca, cd, W + 1); push(1'b1, dw, da, dd, 2 * W + 3); end
         else begin push(1'b1, dw, da, dd, W + 1); push(1'b0, cw, ca, cd, 2 * W + 3); end
      end else if (c) push(1'b0, cw, ca, cd, W + 1);
      else if (d) push(1'b1, dw, da, dd, W + 1);
      cpu_we = cw; cpu_addr = ca; cpu_wdata = cd; cpu_req = c;
      dbg_we = dw; dbg_addr = da; dbg_wdata = dd; dbg_req = d;
      wait_done();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) shd[i] = pat(i);
      #1;
      check("rst_mem_en", {31'b0, mem_en}, 32'd0);
      check("rst_mem_we", {31'b0, mem_we}, 32'd0);
      check("rst_cpu_ack", {31'b0, cpu_ack}, 32'd0);
      check("rst_dbg_ack", {31'b0, dbg_ack}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_rdata", cpu_rdata, 32'h0);
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;
      run(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0);
      run(1'b1, 1'b1, 32'h48, 32'h1111_2222, 1'b1, 1'b0, 32'h48, 32'h0);
      run(1'b1, 1'b0, 32'h48, 32'h0, 1'b1, 1'b1, 32'h4C, 32'h3333_4444);
      run(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      run(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF);
      run(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      run(1'b1, 1'b1, 32'h80, 32'h5555_6666, 1'b0, 1'b0, 32'h0, 32'h0);
      run(1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      run(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4C, 32'h0);
      push(1'b0, 1'b0, 32'h44, 32'h0, W + 1);
      cpu_we = 1'b0; cpu_addr = 32'h44; cpu_req = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #2 check("pre_rst_en", {31'b0, mem_en}, 32'd1);
      rst = 1'b1;
      #1;
      check("abort_mem_en", {31'b0, mem_en}, 32'd0);
      check("abort_cpu_ack", {31'b0, cpu_ack}, 32'd0);
      check("abort_stall", {31'b0, cpu_stall}, 32'd1);
      check("abort_rdata", cpu_rdata, 32'h0);
      @(posedge clk); #1 rst = 1'b0;
      wait_done();
      check("queue_empty", q.size(), 32'd0);
      begin
         int t = 0, last_t = 0, n = 0;
         logic [31:0] cur;
         cur = 32'h200; a1 = cur; r1 = 1'b1;
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            t++;
            check("w1_stall", {31'b0, st1}, {31'b0, ~ack1});
            if (en1) begin
               check("w1_addr", ma1, cur);
               check("w1_we", {31'b0, we1}, 32'd0);
               check("w1_wdata", md1, 32'h0);
            end
            if (ack1) begin
               check("w1_rdata", ra1, cur ^ 32'hA5A5_0000);
               check("w1_dbg", {dra1[30:0], dack1}, {ra1[30:0], 1'b0});
               if (n > 0) check("w1_spacing", t - last_t, 32'd3);
               last_t = t; n++;
               cur += 4;
               @(posedge clk); #1 a1 = cur;
            end
         end
         r1 = 1'b0;
         check("w1_acks", n, 32'd6);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
